// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KeyW = 4;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } state_e;

  localparam logic [3:0] ColPat0 = 4'b0111;
  localparam logic [3:0] ColPat1 = 4'b1011;
  localparam logic [3:0] ColPat2 = 4'b1101;
  localparam logic [3:0] ColPat3 = 4'b1110;

  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    unique case (idx)
      2'd0: pat = ColPat0;
      2'd1: pat = ColPat1;
      2'd2: pat = ColPat2;
      default: pat = ColPat3;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/keypad_encode.sv
// Maps a sampled row pattern and the strobed column to a key code.
// Row index r is carried on row_sample[3-r]; the lowest pressed row wins.
module keypad_encode
  import keypad_pkg::*;
(
  input  logic [3:0]      row_sample,
  input  logic [1:0]      col_index,
  output logic            hit,
  output logic [1:0]      row_index,
  output logic [KeyW-1:0] code
);

  always_comb begin
    hit       = 1'b0;
    row_index = 2'd0;
    // Walk from the highest row down so the lowest pressed row is the last write.
    for (int i = 3; i >= 0; i--) begin
      if (!row_sample[3-i]) begin
        hit       = 1'b1;
        row_index = 2'(i);
      end
    end
    code = {row_index, col_index};
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounce, single-entry key holding register and overrun flag.
// Define KEYPAD_REPEAT_EN to re-issue a held key every REPEAT_SCANS samples.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_BITS      = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      row,
  output logic [3:0]      col,
  output logic [KeyW-1:0] keyCode,
  output logic            keyValid,
  input  logic            keyAck,
  output logic            overrun
);

  localparam int unsigned DebW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]           row_meta;
  logic [3:0]           row_sync;
  logic [SCAN_BITS-1:0] dwell;
  logic [1:0]           col_idx;
  logic [1:0]           rec_row;
  logic [KeyW-1:0]      rec_code;
  logic [DebW-1:0]      deb_cnt;
  state_e               state;

  logic            hit;
  logic [1:0]      hit_row;
  logic [KeyW-1:0] hit_code;
  logic            sample;
  logic            match;
  logic            accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
  logic [RepW-1:0] rep_cnt;
`endif

  keypad_encode u_encode (
    .row_sample(row_sync),
    .col_index (col_idx),
    .hit       (hit),
    .row_index (hit_row),
    .code      (hit_code)
  );

  assign sample = &dwell;
  assign match  = hit && (hit_row == rec_row);
  // A new key may load when the holding register is free or being drained this cycle.
  assign accept = !keyValid || keyAck;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= '0;
      row_sync <= '0;
      dwell    <= '0;
      col_idx  <= '0;
      col      <= 4'b1111;
      rec_row  <= '0;
      rec_code <= '0;
      deb_cnt  <= '0;
      state    <= StScan;
      keyCode  <= '0;
      keyValid <= 1'b0;
      overrun  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt  <= '0;
`endif
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
      dwell    <= dwell + SCAN_BITS'(1);
      col      <= col_pattern(col_idx);
      if (keyValid && keyAck) keyValid <= 1'b0;

      // Transitions happen only on sample cycles, i.e. the edge where dwell wraps.
      if (sample) begin
        unique case (state)
          StScan: begin
            if (hit) begin
              state    <= StDebounce;
              rec_row  <= hit_row;
              rec_code <= hit_code;
              deb_cnt  <= '0;
            end else begin
              col_idx <= col_idx + 2'd1;
              col     <= col_pattern(col_idx + 2'd1);
            end
          end
          StDebounce: begin
            if (!match) begin
              state   <= StScan;
              col_idx <= col_idx + 2'd1;
              col     <= col_pattern(col_idx + 2'd1);
            end else if (deb_cnt == DebW'(DEBOUNCE_SCANS - 1)) begin
              state <= StHeld;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
`endif
              if (accept) begin
                keyCode  <= rec_code;
                keyValid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              deb_cnt <= deb_cnt + DebW'(1);
            end
          end
          StHeld: begin
            if (!hit) begin
              state   <= StRelease;
              deb_cnt <= '0;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rep_cnt == RepW'(REPEAT_SCANS - 1)) begin
              rep_cnt <= '0;
              if (accept) begin
                keyCode  <= rec_code;
                keyValid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              rep_cnt <= rep_cnt + RepW'(1);
            end
`endif
          end
          StRelease: begin
            if (hit) begin
              state <= StHeld;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt <= '0;
`endif
            end else if (deb_cnt == DebW'(DEBOUNCE_SCANS - 1)) begin
              state   <= StScan;
              col_idx <= col_idx + 2'd1;
              col     <= col_pattern(col_idx + 2'd1);
            end else begin
              deb_cnt <= deb_cnt + DebW'(1);
            end
          end
          default: state <= StScan;
        endcase
      end
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_BITS, default 16: per-column dwell counter width; the dwell is 2^SCAN_BITS cycles.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4: number of consecutive identical samples required to accept a press or a release.
REQ-003 SHALL have parameter REPEAT_SCANS, default 64: number of held samples between auto-repeats; used only when KEYPAD_REPEAT_EN is defined.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port row  input  4: keypad row lines, active-low, externally pulled up, synchronised internally.
REQ-007 SHALL have port col  output  4: column strobes, active-low, one-hot-low, registered.
REQ-008 SHALL have port keyCode  output  4: code of the accepted key, equal to row_index*4 + col_index.
REQ-009 SHALL have port keyValid  output  1: high while an unconsumed keyCode is held.
REQ-010 SHALL have port keyAck  input  1: consumer acknowledge, sampled only while keyValid is high.
REQ-011 SHALL have port overrun  output  1: sticky flag indicating a key was lost.

Function
REQ-012 SHALL pass row through a 2-flop synchroniser before any use.
REQ-013 SHALL rotate col through 0111, 1011, 1101, 1110 for col_index 0, 1, 2, 3, advancing when the dwell counter wraps from all-ones to 0.
REQ-014 SHALL take one sample of the synchronised row on the cycle the dwell counter is all-ones; no other cycle is sampled.
REQ-015 SHALL use a state machine with states SCAN, DEBOUNCE, HELD and RELEASE; the reset state is SCAN.
REQ-016 SCAN: a sample with any row low SHALL record col_index and row_index and go to DEBOUNCE; if several rows are low, the lowest row index SHALL be taken.
REQ-017 In DEBOUNCE, HELD and RELEASE, col rotation SHALL stop on the recorded column, and the dwell counter SHALL keep running to pace sampling.
REQ-018 DEBOUNCE: DEBOUNCE_SCANS consecutive samples matching the recorded row SHALL go to HELD; any non-matching sample SHALL return to SCAN and resume rotation from the next column.
REQ-019 On entry to HELD: if keyValid is low, or keyAck is high in the same cycle, keyCode SHALL load the recorded code and keyValid SHALL be high on the next cycle; otherwise keyCode SHALL be kept and overrun SHALL be set.
REQ-020 HELD: a sample with all rows high SHALL go to RELEASE.
REQ-021 RELEASE: DEBOUNCE_SCANS consecutive all-high samples SHALL go to SCAN; any sample with a row low SHALL return to HELD without issuing a new key.
REQ-022 keyValid SHALL clear on the cycle after keyAck is high, unless a new key loads in that same cycle (REQ-019); a new load takes priority.
REQ-023 overrun SHALL stay set until reset.
REQ-024 The dwell counter SHALL wrap modulo 2^SCAN_BITS; the debounce and repeat counters SHALL saturate and never wrap.

Reset
REQ-025 While rst is low, outputs SHALL be: col=1111, keyCode=0, keyValid=0, overrun=0; the dwell, debounce and repeat counters, the synchroniser and the state SHALL be cleared to 0 / SCAN.
REQ-026 col SHALL become 0111 on the first rising clk after rst deasserts.
REQ-027 Reset asserted mid-debounce or mid-hold SHALL abandon the key, with no keyValid pulse issued.

Configuration
REQ-028 With macro KEYPAD_REPEAT_EN defined: after REPEAT_SCANS consecutive held samples in HELD, the key SHALL be re-issued per REQ-019 and the repeat count restarted.
REQ-029 Without KEYPAD_REPEAT_EN: one key is issued per press, there is no repeat counter, and REPEAT_SCANS is ignored.

Structure
REQ-030 The shared package keypad_pkg SHALL hold: the state enum, the col pattern constants 0111/1011/1101/1110, and the key-code width of 4.
REQ-031 The sub-module keypad_encode SHALL be the combinational block mapping (row sample, col_index) to (hit, row_index, code) with lowest-row priority; all other logic SHALL be in keypad_scanner.

Verification (SCAN_BITS=2, DEBOUNCE_SCANS=3, REPEAT_SCANS=5)
REQ-032 Reset release -> col=0111 on the first edge, then 1011, 1101, 1110, 0111 at 4-cycle intervals; keyValid=0.
REQ-033 row=1011 held while col=1101 -> after 3 matching samples keyValid=1, keyCode=6; keyAck pulse -> keyValid=0 on the next cycle.
REQ-034 row=1110 for 1 sample, then 1111 (bounce) -> no keyValid; rotation resumes at the next column.
REQ-035 Key 0 accepted and not acked, released, then key 5 pressed -> keyCode stays 0, overrun=1; keyAck at the same edge as the key-5 load instead -> keyValid stays 1 and keyCode=5.
REQ-036 Rows 0 and 2 low together -> keyCode reports row 0; rst pulse mid-DEBOUNCE -> all outputs at reset values and no key issued.
REQ-037 KEYPAD_REPEAT_EN defined, key held with acks given -> one keyValid per 5 samples; macro undefined -> exactly one keyValid.
